dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the memory end of the CPU datapath's load/store interface.
- Accepts one load or store per handshake, inserts a programmable number of wait states, then returns ready with read data, or an error flag for bad addresses.
- Sits between the datapath's aluout/writedata/readdata path and on-chip RAM; lets the core be exercised against non-zero memory latency.

Parameters:
- ADDR_BITS, 6, word-index width; DEPTH = 2**ADDR_BITS words of 32 bits.
- LATENCY, 2, wait states inserted before the response (legal 0..15).

Ports:
- clk     input   1   clock; all state updates on the rising edge.
- reset   input   1   asynchronous, active-high reset.
- req     input   1   request valid; sampled only in IDLE.
- we      input   1   1 = store, 0 = load; qualified by req.
- addr    input   32  byte address; must be word-aligned.
- wdata   input   32  store data; qualified by req and we.
- ready   output  1   one-cycle response strobe.
- rdata   output  32  load data; valid while ready=1 for a load, held otherwise.
- err     output  1   error flag; valid only while ready=1.
- busy    output  1   1 whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready=0, err=0, busy=0, rdata=32'h0, wait counter=0, latched request cleared. RAM contents are not reset.
- Address checks:
  - Word index = addr[ADDR_BITS+1:2].
  - Misaligned when addr[1:0]!=0.
  - Out of range when addr[31:ADDR_BITS+2]!=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - req=0: stay in IDLE.
  - req=1: latch we, addr index, wdata and error condition; load counter=LATENCY.
  - Next state: WAIT if LATENCY>0, otherwise DONE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 while in WAIT, go to DONE next.
  - Total time in WAIT = LATENCY cycles.
- DONE (exactly one cycle):
  - ready=1 and busy=1.
  - Error case: err=1, no RAM write, rdata unchanged.
  - Good store: RAM[index]<=wdata at the end of this cycle; rdata unchanged; err=0.
  - Good load: rdata=RAM[index], registered so it is valid throughout the DONE cycle; err=0.
  - Always return to IDLE next.
- Timing: req first high in cycle 0 while in IDLE -> ready high in cycle LATENCY+1. The next request can be accepted in cycle LATENCY+2 (back-to-back allowed).
- Handshake rules:
  - req, we, addr and wdata are latched on acceptance; later changes have no effect on the transaction.
  - req is ignored while busy=1; no queueing.
  - req still high in the cycle after ready starts a new transaction. The initiator must drop req after ready unless it wants another access.
- Data hazards: a load immediately following a store to the same index returns the new data. A write-then-read in consecutive transactions needs no bypass, since the write commits before the next acceptance.
- Outputs between responses: rdata holds the last load result; err=0 and ready=0 outside DONE.
- Reset mid-operation: abort immediately to IDLE. A pending store is discarded (writes commit only in DONE). rdata is forced to 0.
- LATENCY=0: IDLE -> DONE; ready appears in cycle 1.

Test Plan (ADDR_BITS=6, LATENCY=2 unless stated):
- Store then load: req/we=1, addr=32'h10, wdata=32'hDEADBEEF in cycle 0 -> ready=1, err=0 in cycle 3. Load from 32'h10 accepted in cycle 4 -> ready in cycle 7 with rdata=32'hDEADBEEF; busy=1 in cycles 5-7.
- Misaligned load: addr=32'h13 -> ready=1, err=1 at cycle 3; rdata unchanged. A subsequent load of 32'h10 returns 32'hDEADBEEF, showing no corruption.
- Out-of-range store: addr=32'h100 (index overflow), wdata=32'h1 -> err=1 with ready. A load of 32'h0 returns its prior value (32'h0 after an initial store of 0), confirming the bad store did not alias into RAM.
- Request while busy: toggle req with addr=32'h20 in cycles 1-2 during a transaction -> ignored; exactly one ready pulse in cycle 3. addr changed after acceptance does not alter the target word.
- Reset mid-store: store accepted in cycle 0, reset pulsed asynchronously in cycle 1 -> ready/busy/rdata go to 0 immediately. A later load of that address returns the old contents, not wdata.
- LATENCY=0 build: back-to-back loads with req held high -> ready in cycles 1, 3, 5; each rdata matches the preloaded word for its address.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store bus between the datapath (master) and the data-memory responder (slave).
// One request per handshake; the responder answers with a single-cycle ready strobe.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        err;
   logic        busy;

   modport master (
      output req, we, addr, wdata,
      input  ready, rdata, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, rdata, err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a programmable number of wait states per access.
// Bad addresses (misaligned or beyond DEPTH) complete with err instead of touching RAM.
module dmem_responder #(
   parameter int ADDR_BITS = 6,
   parameter int LATENCY   = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int         DEPTH = 2 ** ADDR_BITS;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [3:0]             r_waitCount;
   logic                   r_we;
   logic                   r_err;
   logic [ADDR_BITS-1:0]   r_index;
   logic [31:0]            r_wdata;
   logic [31:0]            r_rdata;
   logic [31:0]            r_mem [DEPTH];

   logic                   w_accept;
   logic                   w_badAddr;
   logic                   w_enterDone;
   logic [ADDR_BITS-1:0]   w_reqIndex;
   logic [ADDR_BITS-1:0]   w_rdIndex;
   logic                   w_rdWe;
   logic                   w_rdErr;

   assign w_reqIndex  = bus.addr[ADDR_BITS+1:2];
   assign w_badAddr   = (|bus.addr[1:0]) | (|bus.addr[31:ADDR_BITS+2]);
   assign w_accept    = (r_state == ST_IDLE) && bus.req;
   assign w_enterDone = (w_nextState == ST_DONE);

   // With zero latency DONE follows IDLE directly, so the read must use the live request.
   assign w_rdIndex = (r_state == ST_IDLE) ? w_reqIndex : r_index;
   assign w_rdWe    = (r_state == ST_IDLE) ? bus.we     : r_we;
   assign w_rdErr   = (r_state == ST_IDLE) ? w_badAddr  : r_err;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.req) begin
               w_nextState = (LAT != 4'd0) ? ST_WAIT : ST_DONE;
            end
         end
         ST_WAIT: begin
            if (r_waitCount <= 4'd1) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_waitCount <= 4'd0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_index     <= '0;
         r_wdata     <= 32'h0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_waitCount <= LAT;
            r_we        <= bus.we;
            r_err       <= w_badAddr;
            r_index     <= w_reqIndex;
            r_wdata     <= bus.wdata;
         end else if (r_state == ST_WAIT) begin
            r_waitCount <= r_waitCount - 4'd1;
         end
      end
   end

   // Load data is captured on entry to DONE so it is stable for the whole ready cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= 32'h0;
      end else if (w_enterDone && !w_rdWe && !w_rdErr) begin
         r_rdata <= r_mem[w_rdIndex];
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ST_DONE) && r_we && !r_err) begin
         r_mem[r_index] <= r_wdata;
      end
   end

   assign bus.ready = (r_state == ST_DONE);
   assign bus.err   = (r_state == ST_DONE) && r_err;
   assign bus.busy  = (r_state != ST_IDLE);
   assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance,
// each with its own expectation queue drained by a monitor whenever ready is seen.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   dmem_responder #(.ADDR_BITS(6), .LATENCY(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [32:0] q2 [$];
   logic [32:0] q0 [$];
   logic [31:0] heldRdata2 = 32'h0;
   logic [31:0] heldRdata0 = 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      logic [32:0] e2;
      if (bus2.ready === 1'b1) begin
         if (q2.size() == 0) begin
            checkOutput("dut2 unexpected ready", 32'd1, 32'd0);
         end else begin
            e2 = q2.pop_front();
            checkOutput("dut2 err", {31'd0, bus2.err}, {31'd0, e2[32]});
            checkOutput("dut2 rdata", bus2.rdata, e2[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      logic [32:0] e0;
      if (bus0.ready === 1'b1) begin
         if (q0.size() == 0) begin
            checkOutput("dut0 unexpected ready", 32'd1, 32'd0);
         end else begin
            e0 = q0.pop_front();
            checkOutput("dut0 err", {31'd0, bus0.err}, {31'd0, e0[32]});
            checkOutput("dut0 rdata", bus0.rdata, e0[31:0]);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that starts the next idle cycle.
   task automatic applyStimulus(input bit fast, input logic isStore, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic expErr, input logic [31:0] expLoad);
      int   n;
      int   expCycles;
      logic rdy;
      expCycles = fast ? 1 : 3;
      if (fast) begin
         if (!isStore && !expErr) heldRdata0 = expLoad;
         q0.push_back({expErr, heldRdata0});
         bus0.req = 1'b1; bus0.we = isStore; bus0.addr = addr; bus0.wdata = wdata;
      end else begin
         if (!isStore && !expErr) heldRdata2 = expLoad;
         q2.push_back({expErr, heldRdata2});
         bus2.req = 1'b1; bus2.we = isStore; bus2.addr = addr; bus2.wdata = wdata;
      end
      @(posedge clk); #1;
      if (fast) begin
         bus0.req = 1'b0; bus0.addr = ~addr; bus0.wdata = ~wdata;
      end else begin
         bus2.req = 1'b0; bus2.addr = ~addr; bus2.wdata = ~wdata;
      end
      n   = 1;
      rdy = fast ? bus0.ready : bus2.ready;
      while (!rdy && n < 20) begin
         checkOutput("busy while waiting", {31'd0, fast ? bus0.busy : bus2.busy}, 32'd1);
         @(posedge clk); #1;
         n++;
         rdy = fast ? bus0.ready : bus2.ready;
      end
      checkOutput("busy with ready", {31'd0, fast ? bus0.busy : bus2.busy}, 32'd1);
      checkOutput("response latency", n, expCycles);
      @(posedge clk); #1;
      checkOutput("busy after response", {31'd0, fast ? bus0.busy : bus2.busy}, 32'd0);
      checkOutput("ready after response", {31'd0, fast ? bus0.ready : bus2.ready}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          readyPulses;
      logic [31:0] loadAddr [3];
      logic [31:0] loadData [3];
      loadAddr = '{32'h4, 32'h8, 32'hC};
      loadData = '{32'h11111111, 32'h22222222, 32'h33333333};

      reset = 1'b1;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 32'h0; bus2.wdata = 32'h0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
      #12;
      checkOutput("reset ready", {31'd0, bus2.ready}, 32'd0);
      checkOutput("reset err", {31'd0, bus2.err}, 32'd0);
      checkOutput("reset busy", {31'd0, bus2.busy}, 32'd0);
      checkOutput("reset rdata", bus2.rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] store/load, bad addresses");
      applyStimulus(0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
      applyStimulus(0, 1'b1, 32'h20,  32'h12345678, 1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0);
      applyStimulus(0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
      applyStimulus(0, 1'b1, 32'h0,   32'h0,        1'b0, 32'h0);
      applyStimulus(0, 1'b1, 32'h100, 32'h1,        1'b1, 32'h0);
      applyStimulus(0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0);
      applyStimulus(0, 1'b1, 32'h22,  32'hBADBAD00, 1'b1, 32'h0);
      applyStimulus(0, 1'b0, 32'h20,  32'h0,        1'b0, 32'h12345678);

      $display("[TB] request while busy");
      heldRdata2 = 32'hDEADBEEF;
      q2.push_back({1'b0, 32'hDEADBEEF});
      bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 32'h10;
      readyPulses = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         case (c)
            1: begin bus2.req = 1'b0; bus2.addr = 32'h20; end
            2: bus2.req = 1'b1;
            3: bus2.req = 1'b0;
            default: ;
         endcase
         if (bus2.ready) readyPulses++;
         if (c == 3) checkOutput("busy test ready in cycle 3", {31'd0, bus2.ready}, 32'd1);
      end
      checkOutput("busy test ready pulses", readyPulses, 1);

      $display("[TB] reset mid-store");
      bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h10; bus2.wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus2.req = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("mid-reset ready", {31'd0, bus2.ready}, 32'd0);
      checkOutput("mid-reset busy", {31'd0, bus2.busy}, 32'd0);
      checkOutput("mid-reset rdata", bus2.rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      heldRdata2 = 32'h0;
      heldRdata0 = 32'h0;
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      $display("[TB] zero-latency back-to-back loads");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1'b1, loadAddr[i], loadData[i], 1'b0, 32'h0);
      end
      heldRdata0 = loadData[0];
      q0.push_back({1'b0, loadData[0]});
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = loadAddr[0];
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c % 2 == 1) begin
            checkOutput("zero-latency ready on odd cycle", {31'd0, bus0.ready}, 32'd1);
            if (c < 5) begin
               bus0.addr  = loadAddr[(c + 1) / 2];
               heldRdata0 = loadData[(c + 1) / 2];
               q0.push_back({1'b0, loadData[(c + 1) / 2]});
            end else begin
               bus0.req = 1'b0;
            end
         end else begin
            checkOutput("zero-latency idle on even cycle", {31'd0, bus0.ready}, 32'd0);
         end
      end

      repeat (3) @(posedge clk);
      checkOutput("dut2 queue drained", q2.size(), 0);
      checkOutput("dut0 queue drained", q0.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
